pcie_block_aligner_130b: RTL and testbench
==========================================

Name: pcie_block_aligner_130b

Overview:
- Upstream neighbour of the 128b descrambler in the Gen3 receive lane path.
- Accepts 32-bit deserialized words and gearboxes them into 130-bit blocks.
- Acquires and maintains sync-header block lock.
- Emits each 128-bit payload with a 1-cycle strobe and a control/data flag, directly compatible with the descrambler's in_data / in_valid / in_is_ctl inputs.

Parameters:
- IW, 32, input word width; only 32 is supported. 130×16 = 65×32, so the gearbox pattern repeats every 65 words.
- DW, 128, payload width.
- LOCK_CNT, 8, consecutive good sync headers needed to enter LOCKED.
- UNLOCK_CNT, 4, consecutive bad sync headers in LOCKED that force HUNT.

Ports:
- clk  in  1  lane clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  32  deserialized bits; bit 0 is the earliest received.
- in_valid  in  1  qualifies in_data; gaps are allowed.
- realign  in  1  synchronous pulse: force HUNT and flush the gearbox.
- out_data  out  128  block payload; bit 0 = first payload bit after H1.
- out_valid  out  1  1-cycle strobe per forwarded block.
- out_is_ctl  out  1  1 = ordered-set (control) block.
- out_hdr_err  out  1  valid with out_valid: block carried an illegal header while LOCKED.
- block_lock  out  1  high while state is LOCKED.

Behaviour:
- Reset values: all outputs 0; gearbox fill = 0; state = HUNT; counters = 0.
- Gearbox:
  - 162-bit buffer buf plus fill count (0..161).
  - On an in_valid cycle: comb = buf | (in_data << fill), cfill = fill + 32.
  - Without in_valid: comb = buf, cfill = fill.
  - If cfill >= 130, evaluate blk = comb[129:0]; otherwise buf <= comb, fill <= cfill.
  - At most one block is evaluated per cycle (cfill <= 161).
- Sync header: H0 = blk[0], H1 = blk[1].
  - H0=0, H1=1: data block.
  - H0=1, H1=0: ordered-set block.
  - 00 or 11: bad header.
- Consumption:
  - Normal: remove 130 bits (buf <= comb >> 130, fill <= cfill − 130).
  - Slip (HUNT or CHECK with bad header): remove 131 bits, shifting alignment by one bit.
  - If a slip occurs with cfill = 130, the extra bit is taken from the next valid word. Track this with a pending-slip flag; never underflow.
- FSM:
  - HUNT:
    - bad header → slip, stay in HUNT.
    - good header → CHECK, good_cnt = 1.
  - CHECK:
    - good header → good_cnt + 1; when it reaches LOCK_CNT → LOCKED.
    - bad header → slip, HUNT, good_cnt = 0.
  - LOCKED:
    - good header → bad_cnt = 0.
    - bad header → bad_cnt + 1; when it reaches UNLOCK_CNT → HUNT, bad_cnt = 0, no slip on that block.
- Output:
  - Registered, 1 cycle after the evaluating cycle.
  - out_valid only for blocks evaluated in LOCKED state, including bad-header blocks, which set out_hdr_err = 1 and out_is_ctl = 0.
  - The block that completes lock (the LOCK_CNT-th good header) is not forwarded; forwarding starts with the next block.
  - out_data and out_is_ctl hold their values between strobes.
- block_lock asserts in the cycle after the LOCKED transition and deasserts in the cycle after leaving LOCKED.
- realign has priority over everything that cycle:
  - fill <= 0, pending slip cleared, state HUNT, counters 0.
  - The in_data word presented that cycle is discarded.
  - out_valid = 0 in the next cycle.
- Asynchronous reset mid-block discards partial data; there is no recovery of the buffer.

Decomposition:
- Package pcie_phy_pkg:
  - SH_DATA = 2'b10 and SH_OS = 2'b01, written as {H1,H0}.
  - BLK_W = 130.
  - align_state_e {HUNT, CHECK, LOCKED}.
- One natural sub-module, pcie_gearbox_32to130: buffer, fill, slip input, block-ready output.
- The lock FSM and output register stay in the top.

Test Plan:
- Aligned stream of 20 data blocks (header 10b, payload = block index), in_valid always high → block_lock rises after block 8; blocks 9..20 appear with out_is_ctl = 0, payload 9..20, in order. 65 input words yield exactly 16 strobes.
- Same stream offset by 37 bits → HUNT slips 37 times, then locks; the first forwarded payload has correct content.
- Ordered-set block (header 01b, payload 0xAA…AA) inside a locked stream → out_is_ctl = 1, out_data = 0xAA…AA.
- In LOCKED, inject 3 bad headers (11b) then good ones → three strobes with out_hdr_err = 1; lock is held. Inject 4 consecutive bad headers → block_lock drops after the 4th, with no strobe for the 5th block.
- Random in_valid gaps of 0–3 cycles on an aligned stream → identical payload sequence to the gap-free run; no duplicate or missing strobes.
- realign pulse while LOCKED, then assert rst_n low mid-stream → both return to HUNT, block_lock = 0, and out_valid stays 0 until 8 new good headers are seen.

Source files
------------

// File: rtl/pcie_phy_pkg.sv
// ---------------------------------------------------------------------------
// pcie_phy_pkg
// Shared definitions for the Gen3 receive lane path: 130b block geometry,
// sync-header encodings and the block-alignment state type.
// ---------------------------------------------------------------------------
package pcie_phy_pkg;

    // One 128b/130b block: 2 sync-header bits followed by 128 payload bits.
    localparam int BLK_W = 130;

    // Sync headers written as {H1,H0}; H0 is the first bit on the wire.
    localparam logic [1:0] SH_DATA = 2'b10;
    localparam logic [1:0] SH_OS   = 2'b01;

    typedef enum logic [1:0] {
        HUNT,
        CHECK,
        LOCKED
    } align_state_e;

    // Only the two encodings with differing bits are legal headers.
    function automatic logic sh_is_good(input logic [1:0] sh);
        return (sh == SH_DATA) || (sh == SH_OS);
    endfunction

endpackage

// File: rtl/pcie_gearbox_32to130.sv
// ---------------------------------------------------------------------------
// pcie_gearbox_32to130
// Packs 32-bit deserialized words into 130-bit candidate blocks. A block is
// presented combinationally in the cycle the buffered bit count reaches 130;
// the caller answers with 'slip' in the same cycle to consume 131 bits
// instead of 130, moving the block grid by one bit.
//
// Ports:
//   clk, rst_n  lane clock / asynchronous active-low reset
//   in_data     deserialized word, bit 0 earliest
//   in_valid    qualifies in_data
//   flush       synchronous: empty the buffer, drop in_data this cycle
//   slip        with blk_valid: consume one extra bit
//   blk_data    candidate block, bit 0 = H0
//   blk_valid   blk_data holds a complete block this cycle
// ---------------------------------------------------------------------------
module pcie_gearbox_32to130
    import pcie_phy_pkg::*;
#(
    parameter int IW = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IW-1:0]    in_data,
    input  logic             in_valid,
    input  logic             flush,
    input  logic             slip,
    output logic [BLK_W-1:0] blk_data,
    output logic             blk_valid
);

    // Worst case the buffer holds 129 bits when a new word lands: 161 bits.
    localparam int BUF_W  = BLK_W + IW;
    localparam int FILL_W = $clog2(BUF_W);

    logic [BUF_W-1:0]  buf_q, buf_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              slip_pend_q, slip_pend_d;

    logic [BUF_W-1:0]  word_ext;
    logic [BUF_W-1:0]  comb;
    logic [FILL_W-1:0] cfill;

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        word_ext = '0;
        comb     = buf_q;
        cfill    = fill_q;
        if (in_valid) begin
            // A pending slip owes one bit; it is always the first bit of the
            // next valid word, and the buffer is empty whenever one is owed.
            if (slip_pend_q) begin
                word_ext = BUF_W'(in_data >> 1);
                cfill    = fill_q + FILL_W'(IW - 1);
            end else begin
                word_ext = BUF_W'(in_data);
                cfill    = fill_q + FILL_W'(IW);
            end
            comb = buf_q | (word_ext << fill_q);
        end
        blk_valid = !flush && (cfill >= FILL_W'(BLK_W));
        blk_data  = comb[BLK_W-1:0];
    end

    always_comb begin
        buf_d       = comb;
        fill_d      = cfill;
        slip_pend_d = slip_pend_q && !in_valid;
        if (flush) begin
            buf_d       = '0;
            fill_d      = '0;
            slip_pend_d = 1'b0;
        end else if (blk_valid) begin
            if (!slip) begin
                buf_d  = comb >> BLK_W;
                fill_d = cfill - FILL_W'(BLK_W);
            end else if (cfill == FILL_W'(BLK_W)) begin
                // Nothing left to take the 131st bit from: owe it instead.
                buf_d       = '0;
                fill_d      = '0;
                slip_pend_d = 1'b1;
            end else begin
                buf_d  = comb >> (BLK_W + 1);
                fill_d = cfill - FILL_W'(BLK_W + 1);
            end
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q       <= '0;
            fill_q      <= '0;
            slip_pend_q <= 1'b0;
        end else begin
            buf_q       <= buf_d;
            fill_q      <= fill_d;
            slip_pend_q <= slip_pend_d;
        end
    end

endmodule

// File: rtl/pcie_block_aligner_130b.sv
// ---------------------------------------------------------------------------
// pcie_block_aligner_130b
// Gen3 receive-lane block aligner. Gearboxes 32-bit words into 130-bit
// blocks, hunts for sync-header lock by slipping one bit per bad header,
// and forwards the 128-bit payload of every block evaluated while LOCKED,
// one cycle after evaluation, in the descrambler's input format.
//
// Ports:
//   clk, rst_n   lane clock / asynchronous active-low reset
//   in_data      deserialized bits, bit 0 earliest
//   in_valid     qualifies in_data
//   realign      synchronous pulse: back to HUNT, gearbox flushed
//   out_data     block payload, bit 0 = first bit after H1
//   out_valid    one-cycle strobe per forwarded block
//   out_is_ctl   forwarded block is an ordered set
//   out_hdr_err  forwarded block carried an illegal sync header
//   block_lock   high while LOCKED
// ---------------------------------------------------------------------------
module pcie_block_aligner_130b
    import pcie_phy_pkg::*;
#(
    parameter int IW         = 32,   // only 32 is supported
    parameter int DW         = 128,  // only 128 is supported
    parameter int LOCK_CNT   = 8,
    parameter int UNLOCK_CNT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [IW-1:0] in_data,
    input  logic          in_valid,
    input  logic          realign,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    output logic          out_is_ctl,
    output logic          out_hdr_err,
    output logic          block_lock
);

    localparam int GCW = $clog2(LOCK_CNT + 1);
    localparam int BCW = $clog2(UNLOCK_CNT + 1);

    logic [BLK_W-1:0] blk_data;
    logic             blk_valid;
    logic             slip;
    logic [1:0]       hdr;
    logic             hdr_good;

    align_state_e     state_q, state_d;
    logic [GCW-1:0]   good_cnt_q, good_cnt_d;
    logic [BCW-1:0]   bad_cnt_q, bad_cnt_d;

    logic [DW-1:0]    out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             out_is_ctl_q, out_is_ctl_d;
    logic             out_hdr_err_q, out_hdr_err_d;

    pcie_gearbox_32to130 #(
        .IW (IW)
    ) u_gearbox (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .flush     (realign),
        .slip      (slip),
        .blk_data  (blk_data),
        .blk_valid (blk_valid)
    );

    assign hdr      = {blk_data[1], blk_data[0]};
    assign hdr_good = sh_is_good(hdr);

    always_comb begin
        state_d       = state_q;
        good_cnt_d    = good_cnt_q;
        bad_cnt_d     = bad_cnt_q;
        slip          = 1'b0;
        out_valid_d   = 1'b0;
        out_hdr_err_d = 1'b0;
        out_data_d    = out_data_q;
        out_is_ctl_d  = out_is_ctl_q;

        if (realign) begin
            // The gearbox flushes on the same pulse, so any block it would
            // have presented this cycle is ignored.
            state_d    = HUNT;
            good_cnt_d = '0;
            bad_cnt_d  = '0;
        end else if (blk_valid) begin
            unique case (state_q)
                HUNT: begin
                    if (hdr_good) begin
                        state_d    = CHECK;
                        good_cnt_d = GCW'(1);
                    end else begin
                        slip = 1'b1;
                    end
                end
                CHECK: begin
                    if (hdr_good) begin
                        // The block that completes lock is not forwarded.
                        if (good_cnt_q == GCW'(LOCK_CNT - 1)) begin
                            state_d    = LOCKED;
                            good_cnt_d = '0;
                        end else begin
                            good_cnt_d = good_cnt_q + GCW'(1);
                        end
                    end else begin
                        slip       = 1'b1;
                        state_d    = HUNT;
                        good_cnt_d = '0;
                    end
                end
                LOCKED: begin
                    out_valid_d   = 1'b1;
                    out_data_d    = blk_data[BLK_W-1:2];
                    out_is_ctl_d  = (hdr == SH_OS);
                    out_hdr_err_d = !hdr_good;
                    if (hdr_good) begin
                        bad_cnt_d = '0;
                    end else if (bad_cnt_q == BCW'(UNLOCK_CNT - 1)) begin
                        // Losing lock keeps the current grid: no slip here.
                        state_d   = HUNT;
                        bad_cnt_d = '0;
                    end else begin
                        bad_cnt_d = bad_cnt_q + BCW'(1);
                    end
                end
                default: begin
                    state_d    = HUNT;
                    good_cnt_d = '0;
                    bad_cnt_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= HUNT;
            good_cnt_q    <= '0;
            bad_cnt_q     <= '0;
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            out_is_ctl_q  <= 1'b0;
            out_hdr_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            good_cnt_q    <= good_cnt_d;
            bad_cnt_q     <= bad_cnt_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
            out_is_ctl_q  <= out_is_ctl_d;
            out_hdr_err_q <= out_hdr_err_d;
        end
    end

    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign out_is_ctl  = out_is_ctl_q;
    assign out_hdr_err = out_hdr_err_q;
    assign block_lock  = (state_q == LOCKED);

endmodule

// File: tb/tb_pcie_block_aligner_130b.sv
// ---------------------------------------------------------------------------
// tb_pcie_block_aligner_130b
// Directed and randomized stimulus for the 130b block aligner. A bit-queue
// reference model (words in, 130/131-bit blocks out, lock rules applied per
// block) predicts every output each cycle; directed scenarios add explicit
// checks on strobe counts and payload order.
// ---------------------------------------------------------------------------
module tb_pcie_block_aligner_130b;

    localparam logic [1:0] H_DATA = 2'b10;  // {H1,H0}
    localparam logic [1:0] H_OS   = 2'b01;
    localparam logic [1:0] H_BAD  = 2'b11;
    localparam int M_LOCK   = 8;
    localparam int M_UNLOCK = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  in_data;
    logic         in_valid;
    logic         realign;
    logic [127:0] out_data;
    logic         out_valid;
    logic         out_is_ctl;
    logic         out_hdr_err;
    logic         block_lock;

    always #5 clk = ~clk;

    pcie_block_aligner_130b dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .realign     (realign),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_is_ctl  (out_is_ctl),
        .out_hdr_err (out_hdr_err),
        .block_lock  (block_lock)
    );

    int n_cmp = 0;
    int n_mis = 0;

    // ---------------- reference model ----------------
    typedef enum {M_HUNT, M_CHECK, M_LOCKED} mstate_e;
    bit           mq[$];      // received, not yet consumed bits
    int           m_debt;     // bits still owed to a slip
    mstate_e      m_st;
    int           m_good;
    int           m_bad;
    logic         exp_valid, exp_ctl, exp_err, exp_lock;
    logic [127:0] exp_data;

    // ---------------- stimulus / observation ----------------
    bit           sq[$];
    logic [127:0] got_pay[$];
    bit           got_ctl[$];
    bit           got_err[$];
    int           n_strobes = 0;
    int           strobe_mark[1024];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        mq.delete();
        m_debt    = 0;
        m_st      = M_HUNT;
        m_good    = 0;
        m_bad     = 0;
        exp_valid = 1'b0;
        exp_ctl   = 1'b0;
        exp_err   = 1'b0;
        exp_lock  = 1'b0;
        exp_data  = '0;
    endfunction

    function automatic void model_step(input bit v, input logic [31:0] d, input bit ra);
        logic [129:0] blk;
        bit           good;
        int           n;
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        if (ra) begin
            mq.delete();
            m_debt = 0;
            m_st   = M_HUNT;
            m_good = 0;
            m_bad  = 0;
        end else begin
            if (v) begin
                for (int b = 0; b < 32; b++) begin
                    if (m_debt > 0) m_debt--;
                    else mq.push_back(d[b]);
                end
            end
            if (mq.size() >= 130) begin
                for (int b = 0; b < 130; b++) blk[b] = mq[b];
                good = (blk[0] != blk[1]);
                n = 130;
                case (m_st)
                    M_HUNT: begin
                        if (good) begin m_st = M_CHECK; m_good = 1; end
                        else n = 131;
                    end
                    M_CHECK: begin
                        if (good) begin
                            m_good++;
                            if (m_good == M_LOCK) begin m_st = M_LOCKED; m_good = 0; end
                        end else begin
                            n = 131; m_st = M_HUNT; m_good = 0;
                        end
                    end
                    default: begin
                        exp_valid = 1'b1;
                        exp_data  = blk[129:2];
                        exp_ctl   = good && blk[0];
                        exp_err   = !good;
                        if (good) m_bad = 0;
                        else begin
                            m_bad++;
                            if (m_bad == M_UNLOCK) begin m_st = M_HUNT; m_bad = 0; end
                        end
                    end
                endcase
                for (int b = 0; b < n; b++) begin
                    if (mq.size() > 0) void'(mq.pop_front());
                    else m_debt++;
                end
            end
        end
        exp_lock = (m_st == M_LOCKED);
    endfunction

    function automatic void add_block(input logic [1:0] sh, input logic [127:0] pay);
        sq.push_back(sh[0]);
        sq.push_back(sh[1]);
        for (int i = 0; i < 128; i++) sq.push_back(pay[i]);
    endfunction

    function automatic logic [31:0] pop_word();
        logic [31:0] w;
        for (int b = 0; b < 32; b++) w[b] = (sq.size() > 0) ? sq.pop_front() : 1'b0;
        return w;
    endfunction

    function automatic void clear_got();
        got_pay.delete();
        got_ctl.delete();
        got_err.delete();
    endfunction

    // One clock: drive, predict, clock, compare #1 after the edge.
    task automatic step(input bit v, input logic [31:0] d, input bit ra);
        in_valid = v;
        in_data  = d;
        realign  = ra;
        model_step(v, d, ra);
        @(posedge clk);
        #1;
        check("out_valid",  128'(out_valid),  128'(exp_valid));
        check("block_lock", 128'(block_lock), 128'(exp_lock));
        check("out_data",   out_data,         exp_data);
        check("out_is_ctl", 128'(out_is_ctl), 128'(exp_ctl));
        if (exp_valid) check("out_hdr_err", 128'(out_hdr_err), 128'(exp_err));
        if (out_valid === 1'b1) begin
            got_pay.push_back(out_data);
            got_ctl.push_back(out_is_ctl);
            got_err.push_back(out_hdr_err);
            n_strobes++;
        end
        in_valid = 1'b0;
        realign  = 1'b0;
    endtask

    task automatic feed(input int gap_max, input int max_words);
        int w = 0;
        while (sq.size() > 0 && (max_words < 0 || w < max_words)) begin
            if (w < 1024) strobe_mark[w] = n_strobes;
            step(1'b1, pop_word(), 1'b0);
            repeat ($urandom_range(gap_max, 0)) step(1'b0, $urandom, 1'b0);
            w++;
        end
        if (w < 1024) strobe_mark[w] = n_strobes;
    endtask

    task automatic apply_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        realign  = 1'b0;
        in_data  = '0;
        model_reset();
        sq.delete();
        clear_got();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int nerr;
        logic [1:0] sh;
        int r;

        // ---------- reset state ----------
        apply_reset();
        check("rst_out_valid",   128'(out_valid),   128'(0));
        check("rst_out_data",    out_data,          128'(0));
        check("rst_out_is_ctl",  128'(out_is_ctl),  128'(0));
        check("rst_out_hdr_err", 128'(out_hdr_err), 128'(0));
        check("rst_block_lock",  128'(block_lock),  128'(0));

        // ---------- aligned gap-free stream ----------
        for (int i = 1; i <= 40; i++) add_block(H_DATA, 128'(i));
        feed(0, -1);
        check("t1_strobes", 128'(got_pay.size()), 128'(32));
        for (int k = 0; k < got_pay.size() && k < 32; k++) begin
            check("t1_payload", got_pay[k], 128'(k + 9));
            check("t1_is_ctl",  128'(got_ctl[k]), 128'(0));
        end
        check("t1_65_words", 128'(strobe_mark[130] - strobe_mark[65]), 128'(16));

        // ---------- stream offset by 37 bits ----------
        apply_reset();
        for (int i = 0; i < 37; i++) sq.push_back(1'b0);
        for (int i = 1; i <= 50; i++) add_block(H_DATA, 128'(i));
        feed(0, -1);
        check("t2_strobes", 128'(got_pay.size()), 128'(5));
        if (got_pay.size() > 0) check("t2_first_payload", got_pay[0], 128'(46));

        // ---------- ordered set and bad headers while locked ----------
        apply_reset();
        for (int i = 1; i <= 30; i++) begin
            if (i == 12) add_block(H_OS, {16{8'hAA}});
            else if ((i >= 14 && i <= 16) || (i >= 20 && i <= 23)) add_block(H_BAD, 128'(i));
            else add_block(H_DATA, 128'(i));
        end
        feed(0, -1);
        check("t3_strobes", 128'(got_pay.size()), 128'(15));
        if (got_pay.size() > 3) begin
            check("t3_os_ctl",  128'(got_ctl[3]), 128'(1));
            check("t3_os_data", got_pay[3], {16{8'hAA}});
        end
        nerr = 0;
        for (int k = 0; k < got_err.size(); k++) if (got_err[k]) nerr++;
        check("t3_hdr_errs", 128'(nerr), 128'(7));
        check("t3_unlocked", 128'(block_lock), 128'(0));

        // ---------- random in_valid gaps ----------
        apply_reset();
        for (int i = 1; i <= 20; i++) add_block(H_DATA, 128'(i));
        feed(3, -1);
        check("t4_strobes", 128'(got_pay.size()), 128'(12));
        for (int k = 0; k < got_pay.size() && k < 12; k++)
            check("t4_payload", got_pay[k], 128'(k + 9));

        // ---------- realign while locked, then async reset mid-stream ----------
        apply_reset();
        for (int i = 1; i <= 30; i++) add_block(H_DATA, 128'(i));
        feed(1, 60);
        check("t5_locked_before", 128'(block_lock), 128'(1));
        step(1'b1, pop_word(), 1'b1);
        check("t5_ra_lock",  128'(block_lock), 128'(0));
        check("t5_ra_valid", 128'(out_valid),  128'(0));
        feed(1, 20);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("t5_arst_valid", 128'(out_valid),   128'(0));
        check("t5_arst_lock",  128'(block_lock),  128'(0));
        check("t5_arst_data",  out_data,          128'(0));
        check("t5_arst_ctl",   128'(out_is_ctl),  128'(0));
        check("t5_arst_err",   128'(out_hdr_err), 128'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sq.delete();
        clear_got();
        for (int i = 1; i <= 20; i++) add_block(H_DATA, 128'(i + 100));
        feed(2, -1);
        check("t5_relock_strobes", 128'(got_pay.size()), 128'(12));
        if (got_pay.size() > 0) check("t5_relock_first", got_pay[0], 128'(109));

        // ---------- randomized stream against the model ----------
        apply_reset();
        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(99, 0);
            if (r < 88)      sh = H_DATA;
            else if (r < 94) sh = H_OS;
            else             sh = ($urandom_range(1, 0) == 0) ? 2'b00 : 2'b11;
            add_block(sh, {$urandom, $urandom, $urandom, $urandom});
        end
        feed(2, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
